// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control for the
// 4-bit-opcode CPU. Owns the shared memory handshake, times the PC/IR/RF
// strobes and counts retired instructions.
module instr_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [3:0]       opcode,
   input  logic             eq,
   input  logic             mem_ready,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             addr_sel,
   output logic             ir_load,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             rf_we,
   output logic             busy,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] retired_q;
   logic             fetch_pend_q, fetch_pend_d;
   logic             retire_c;
   logic             mem_rd_c, mem_wr_c, addr_sel_c, ir_load_c;
   logic             pc_inc_c, pc_load_c, rf_we_c, busy_c;

   // Instruction class decode; everything not listed is ALU class.
   logic is_jmp, is_beq, is_bne, is_lw, is_sw, taken;
   assign is_jmp = (opcode == 4'b0111);
   assign is_beq = (opcode == 4'b1000);
   assign is_bne = (opcode == 4'b1001);
   assign is_lw  = (opcode == 4'b1110);
   assign is_sw  = (opcode == 4'b1111);
   assign taken  = is_beq ? eq : ~eq;

   // State, pending-fetch flag and retire counter; reset drops any request.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_FETCH;
         retired_q    <= '0;
         fetch_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pend_q <= fetch_pend_d;
         if (retire_c)
            retired_q <= retired_q + 1'b1;
      end
   end

   // Next-state logic; a started fetch is held even if run drops.
   always_comb begin
      state_d      = S_FETCH;
      fetch_pend_d = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            state_d      = S_FETCH;
            fetch_pend_d = (run || fetch_pend_q) && !mem_ready;
            if ((run || fetch_pend_q) && mem_ready)
               state_d = S_DECODE;
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (is_jmp || is_beq || is_bne) state_d = S_FETCH;
            else if (is_lw || is_sw)        state_d = S_MEM;
            else                            state_d = S_WB;
         end
         S_MEM: begin
            state_d = S_MEM;
            if (mem_ready)
               state_d = is_sw ? S_FETCH : S_WB;
         end
         S_WB:    state_d = S_FETCH;
         default: state_d = S_FETCH;
      endcase
   end

   // Strobe decode from current state; illegal encodings drive nothing.
   always_comb begin
      mem_rd_c   = 1'b0;
      mem_wr_c   = 1'b0;
      addr_sel_c = 1'b0;
      ir_load_c  = 1'b0;
      pc_inc_c   = 1'b0;
      pc_load_c  = 1'b0;
      rf_we_c    = 1'b0;
      retire_c   = 1'b0;
      busy_c     = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            if (run || fetch_pend_q) begin
               mem_rd_c  = 1'b1;
               ir_load_c = mem_ready;
               busy_c    = 1'b1;
            end
         end
         S_DECODE: busy_c = 1'b1;
         S_EXEC: begin
            busy_c = 1'b1;
            if (is_jmp) begin
               pc_load_c = 1'b1;
               retire_c  = 1'b1;
            end else if (is_beq || is_bne) begin
               pc_load_c = taken;
               pc_inc_c  = ~taken;
               retire_c  = 1'b1;
            end
         end
         S_MEM: begin
            busy_c     = 1'b1;
            addr_sel_c = 1'b1;
            mem_rd_c   = ~is_sw;
            mem_wr_c   = is_sw;
            if (is_sw && mem_ready) begin
               pc_inc_c = 1'b1;
               retire_c = 1'b1;
            end
         end
         S_WB: begin
            busy_c   = 1'b1;
            rf_we_c  = 1'b1;
            pc_inc_c = 1'b1;
            retire_c = 1'b1;
         end
         default: ;
      endcase
   end

   // Everything is forced quiet while reset is asserted.
   assign mem_rd   = rst_n & mem_rd_c;
   assign mem_wr   = rst_n & mem_wr_c;
   assign addr_sel = rst_n & addr_sel_c;
   assign ir_load  = rst_n & ir_load_c;
   assign pc_inc   = rst_n & pc_inc_c;
   assign pc_load  = rst_n & pc_load_c;
   assign rf_we    = rst_n & rf_we_c;
   assign busy     = rst_n & busy_c;
   assign state    = rst_n ? state_q : S_FETCH;
   assign retired  = rst_n ? retired_q : '0;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle vector table plus
// hand sequences for wait states, run gating and counter wrap.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, run, eq, mem_ready;
   logic [3:0]  opcode;
   logic        mem_rd, mem_wr, addr_sel, ir_load, pc_inc, pc_load, rf_we, busy;
   logic [2:0]  state;
   logic [15:0] retired;
   logic        m4_rd, m4_wr, m4_as, m4_irl, m4_pci, m4_pcl, m4_we, m4_busy;
   logic [2:0]  state4;
   logic [3:0]  retired4;
   logic [7:0]  strb, strb4;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   instr_sequencer #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .eq(eq),
      .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .addr_sel(addr_sel), .ir_load(ir_load), .pc_inc(pc_inc),
      .pc_load(pc_load), .rf_we(rf_we), .busy(busy), .state(state),
      .retired(retired));

   instr_sequencer #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .eq(eq),
      .mem_ready(mem_ready), .mem_rd(m4_rd), .mem_wr(m4_wr),
      .addr_sel(m4_as), .ir_load(m4_irl), .pc_inc(m4_pci),
      .pc_load(m4_pcl), .rf_we(m4_we), .busy(m4_busy), .state(state4),
      .retired(retired4));

   // strobe bus order: mem_rd mem_wr addr_sel ir_load pc_inc pc_load rf_we busy
   assign strb  = {mem_rd, mem_wr, addr_sel, ir_load, pc_inc, pc_load, rf_we, busy};
   assign strb4 = {m4_rd, m4_wr, m4_as, m4_irl, m4_pci, m4_pcl, m4_we, m4_busy};

   typedef struct {
      logic        r, run;
      logic [3:0]  op;
      logic        eq, rdy;
      logic [2:0]  st;
      logic [7:0]  s;
      logic [15:0] ret;
   } vec_t;

   localparam logic [7:0] FI  = 8'b1001_0001; // fetch completing
   localparam logic [7:0] FW  = 8'b1000_0001; // fetch waiting
   localparam logic [7:0] DEC = 8'b0000_0001; // busy, no strobes
   localparam logic [7:0] WB  = 8'b0000_1011;
   localparam logic [7:0] PCL = 8'b0000_0101;
   localparam logic [7:0] PCI = 8'b0000_1001;
   localparam logic [7:0] MLW = 8'b1010_0001;
   localparam logic [7:0] MSW = 8'b0110_0001;
   localparam logic [7:0] MSD = 8'b0110_1001;

   vec_t vt[38];

   function automatic vec_t mk(logic r, logic rn, logic [3:0] op, logic e,
                               logic rd, logic [2:0] st, logic [7:0] s,
                               logic [15:0] ret);
      vec_t v;
      v.r = r; v.run = rn; v.op = op; v.eq = e; v.rdy = rd;
      v.st = st; v.s = s; v.ret = ret;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // set inputs (just after a rising edge) and move to the sampling point
   task automatic drive(input logic rn, input logic [3:0] op, input logic e,
                        input logic rd);
      run = rn; opcode = op; eq = e; mem_ready = rd;
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; run = 1'b0; opcode = 4'h0; eq = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   int wecnt;
   logic [2:0] pat [4];

   initial begin
      vt[0]  = mk(0,1,4'hF,0,0, 3'd0, 8'h00, 0);
      vt[1]  = mk(1,1,4'h4,0,1, 3'd0, FI,  0);
      vt[2]  = mk(1,1,4'h4,0,1, 3'd1, DEC, 0);
      vt[3]  = mk(1,1,4'h4,0,1, 3'd2, DEC, 0);
      vt[4]  = mk(1,1,4'h4,0,1, 3'd4, WB,  0);
      vt[5]  = mk(1,1,4'h8,1,1, 3'd0, FI,  1);
      vt[6]  = mk(1,1,4'h8,1,1, 3'd1, DEC, 1);
      vt[7]  = mk(1,1,4'h8,1,1, 3'd2, PCL, 1);
      vt[8]  = mk(1,1,4'h8,0,1, 3'd0, FI,  2);
      vt[9]  = mk(1,1,4'h8,0,1, 3'd1, DEC, 2);
      vt[10] = mk(1,1,4'h8,0,1, 3'd2, PCI, 2);
      vt[11] = mk(1,1,4'h9,1,1, 3'd0, FI,  3);
      vt[12] = mk(1,1,4'h9,1,1, 3'd1, DEC, 3);
      vt[13] = mk(1,1,4'h9,1,1, 3'd2, PCI, 3);
      vt[14] = mk(1,1,4'hE,0,0, 3'd0, FW,  4);
      vt[15] = mk(1,0,4'hE,0,0, 3'd0, FW,  4);
      vt[16] = mk(1,0,4'hE,0,1, 3'd0, FI,  4);
      vt[17] = mk(1,1,4'hE,0,1, 3'd1, DEC, 4);
      vt[18] = mk(1,1,4'hE,0,1, 3'd2, DEC, 4);
      vt[19] = mk(1,1,4'hE,0,0, 3'd3, MLW, 4);
      vt[20] = mk(1,1,4'hE,0,1, 3'd3, MLW, 4);
      vt[21] = mk(1,1,4'hE,0,1, 3'd4, WB,  4);
      vt[22] = mk(1,0,4'hF,0,1, 3'd0, 8'h00, 5);
      vt[23] = mk(1,1,4'hF,0,1, 3'd0, FI,  5);
      vt[24] = mk(1,1,4'hF,0,1, 3'd1, DEC, 5);
      vt[25] = mk(1,1,4'hF,0,1, 3'd2, DEC, 5);
      vt[26] = mk(1,1,4'hF,0,0, 3'd3, MSW, 5);
      vt[27] = mk(1,1,4'hF,0,1, 3'd3, MSD, 5);
      vt[28] = mk(1,1,4'h7,0,1, 3'd0, FI,  6);
      vt[29] = mk(1,1,4'h7,0,1, 3'd1, DEC, 6);
      vt[30] = mk(1,1,4'h7,0,1, 3'd2, PCL, 6);
      vt[31] = mk(1,1,4'hF,0,1, 3'd0, FI,  7);
      vt[32] = mk(1,1,4'hF,0,1, 3'd1, DEC, 7);
      vt[33] = mk(1,1,4'hF,0,1, 3'd2, DEC, 7);
      vt[34] = mk(1,1,4'hF,0,0, 3'd3, MSW, 7);
      vt[35] = mk(0,1,4'hF,0,1, 3'd0, 8'h00, 0);
      vt[36] = mk(0,1,4'hF,0,1, 3'd0, 8'h00, 0);
      vt[37] = mk(1,0,4'hF,0,1, 3'd0, 8'h00, 0);
      pat[0] = 3'd0; pat[1] = 3'd1; pat[2] = 3'd2; pat[3] = 3'd4;

      // table: one record per clock cycle
      for (int i = 0; i < 38; i++) begin
         rst_n = vt[i].r;
         drive(vt[i].run, vt[i].op, vt[i].eq, vt[i].rdy);
         chk($sformatf("vec%0d_state", i), 32'(state), 32'(vt[i].st));
         chk($sformatf("vec%0d_strobes", i), 32'(strb), 32'(vt[i].s));
         chk($sformatf("vec%0d_retired", i), 32'(retired), 32'(vt[i].ret));
         chk($sformatf("vec%0d_strobes_w4", i), 32'(strb4), 32'(vt[i].s));
         adv();
      end

      // ALU stream, zero-wait: 3 instructions in 12 cycles
      do_reset();
      wecnt = 0;
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 4'h4, 1'b0, 1'b1);
         chk("alu_state", 32'(state), 32'(pat[i % 4]));
         if (rf_we) wecnt++;
         adv();
      end
      drive(1'b0, 4'h4, 1'b0, 1'b0);
      chk("alu_retired", 32'(retired), 32'd3);
      chk("alu_rf_we_pulses", 32'(wecnt), 32'd3);
      adv();

      // LW with 2 fetch waits and 3 memory waits: 10 cycles
      do_reset();
      wecnt = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 4'hE, 1'b0,
               (i == 0 || i == 1 || i == 5 || i == 6 || i == 7) ? 1'b0 : 1'b1);
         if (i <= 2 || (i >= 5 && i <= 8))
            chk($sformatf("lw_mem_rd_c%0d", i), 32'(mem_rd), 32'd1);
         if (i == 9) chk("lw_wb_state", 32'(state), 32'd4);
         if (rf_we) wecnt++;
         adv();
      end
      drive(1'b0, 4'hE, 1'b0, 1'b0);
      chk("lw_back_to_fetch", 32'(state), 32'd0);
      chk("lw_retired", 32'(retired), 32'd1);
      chk("lw_rf_we_pulses", 32'(wecnt), 32'd1);
      adv();

      // run low: no requests, not busy
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 4'h4, 1'b0, 1'b1);
         chk("idle_mem_rd", 32'(mem_rd), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
         adv();
      end

      // 16 JMPs: 4-bit counter wraps 15 -> 0
      do_reset();
      for (int i = 0; i < 48; i++) begin
         drive(1'b1, 4'h7, 1'b0, 1'b1);
         if (i == 45) chk("wrap_pre", 32'(retired4), 32'd15);
         adv();
      end
      drive(1'b0, 4'h7, 1'b0, 1'b0);
      chk("wrap_post", 32'(retired4), 32'd0);
      chk("wrap_wide", 32'(retired), 32'd16);
      adv();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle sequencer for the 4-bit-opcode CPU datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states. It drives the PC, instruction-register, register-file and memory strobes that the combinational opcode decoder cannot time by itself. It sits between the instruction register and the decoder/datapath, owns the single shared memory port handshake, and counts retired instructions.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- run  in  1  fetch enable; sampled only in FETCH before a request is issued
- opcode  in  4  IR[15:12]; valid from DECODE onward, stable until next ir_load
- eq  in  1  comparator equal flag from datapath; valid in EXEC
- mem_ready  in  1  memory completes current access this cycle
- mem_rd  out  1  memory read request (instruction or lw data)
- mem_wr  out  1  memory write request (sw)
- addr_sel  out  1  0 = PC drives memory address, 1 = ALU/data address
- ir_load  out  1  load IR from memory read data
- pc_inc  out  1  PC <= PC + 1
- pc_load  out  1  PC <= branch/jump target
- rf_we  out  1  register-file write enable
- busy  out  1  instruction in flight (state != FETCH, or FETCH with mem_rd high)
- state  out  3  current state; FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
- retired  out  CNT_W  retired-instruction count

## Operation
- Class decode, from opcode:
  - ALU class = 0000–0110 and 1010–1101.
  - JMP = 0111.
  - BEQ = 1000.
  - BNE = 1001.
  - LW = 1110.
  - SW = 1111.
- Outputs are combinational from the state register, opcode, eq, mem_ready and run. All outputs are 0 while rst_n = 0.
- FETCH:
  - If run = 1: mem_rd = 1 and addr_sel = 0.
  - Stay in FETCH while mem_ready = 0.
  - When mem_ready = 1: ir_load = 1 in the same cycle, and the next state is DECODE.
  - If run = 0: no request; stay in FETCH.
- DECODE: no strobes; unconditionally go to EXEC.
- EXEC:
  - ALU class: go to WB.
  - JMP: pc_load = 1; go to FETCH; retire.
  - BEQ: taken = eq. BNE: taken = ~eq.
  - For BEQ/BNE: pc_load = taken and pc_inc = ~taken; go to FETCH; retire.
  - LW/SW: go to MEM.
- MEM:
  - addr_sel = 1; mem_rd = 1 for LW, mem_wr = 1 for SW.
  - Held until mem_ready = 1.
  - On completion, LW goes to WB.
  - On completion, SW asserts pc_inc = 1, goes to FETCH and retires.
- WB: rf_we = 1 and pc_inc = 1; go to FETCH; retire.
- Invariants:
  - pc_inc and pc_load are never both 1.
  - mem_rd and mem_wr are never both 1.
  - rf_we is 1 only in WB.
- Retirement: retired increments by 1 on the clock edge that leaves the final state of an instruction. It wraps from 2^CNT_W−1 to 0.
- Illegal state encodings 5–7 return to FETCH next cycle with all strobes 0. They do not retire.

## Timing
- Reset: on a rising edge with rst_n = 0:
  - state is set to FETCH and retired to 0.
  - All outputs are 0 during the reset cycle.
- Reset mid-operation: an outstanding memory request is dropped immediately. A mem_ready arriving in the reset cycle is ignored.
- Zero-wait latency (mem_ready = 1 whenever requested):
  - ALU: 4 cycles.
  - JMP/BEQ/BNE: 3 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
- Each cycle with a pending request and mem_ready = 0 adds exactly 1 cycle.
- mem_ready outside FETCH/MEM, or with no request pending, is ignored.
- run dropping while a fetch request is pending: the request is held until mem_ready. A started fetch is never abandoned.
- opcode or eq changes in FETCH have no effect.

## Test plan
- Reset: rst_n = 0 for 2 cycles in MEM with mem_wr high -> next cycle state = 0, all strobes 0, retired = 0.
- ALU stream, zero-wait: opcode 0100 ×3 with run = 1 -> states 0,1,2,4 repeating; rf_we pulses 3 times; retired = 3 after 12 cycles.
- Branches:
  - BEQ with eq = 1 -> pc_load pulse in EXEC.
  - BEQ with eq = 0 -> pc_inc pulse.
  - BNE with eq = 1 -> pc_inc pulse.
  - Each takes 3 cycles.
- Memory waits:
  - LW with mem_ready low 2 cycles in FETCH and 3 in MEM -> 10 cycles total; mem_rd held continuously; one rf_we in WB.
  - SW -> mem_wr only, no rf_we.
- run gating: run = 0 in FETCH for 5 cycles -> no mem_rd, busy = 0. Deassert run during a pending fetch -> request held to mem_ready.
- Wrap: CNT_W = 4, 16 JMPs -> retired goes from 15 to 0.
